// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Constants shared by the xbit ALU blocks: FSM state encodings for the
//   serial add/sub controller and the op_sub opcode values.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Serial controller FSM encodings. Kept as plain 2-bit constants so that
    // older blocks comparing raw state bits stay compatible.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // op_sub encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//   Combinational 1-bit full adder built from two half adders plus an OR on
//   the carries. This is the only arithmetic in the serial controller; it is
//   reused once per operand bit.
//   Ports:
//     a, b  in   operand bits
//     cin   in   carry in
//     s     out  sum bit
//     cout  out  carry out (majority of a, b, cin)
// ---------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // Both half-adder carries can never be high together, so OR is the
    // majority function here.
    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   Combinational 1-bit half adder.
//   Ports:
//     a, b  in   addend bits
//     s     out  sum      (a ^ b)
//     c     out  carry    (a & b)
// ---------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract controller. One fa_cell is time-shared across
//   WIDTH operand bits, LSB first. A start pulse in IDLE captures the
//   operands; WIDTH RUN cycles later the result and flags are presented with
//   a one-cycle done pulse.
//
//   Parameters:
//     WIDTH   operand/result width, 2..32
//     CNT_W   bit-counter width, derived from WIDTH
//
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   synchronous reset, active-high, dominates start
//     start   in   request, only honoured in IDLE
//     op_sub  in   0 = A+B, 1 = A-B (captured with start)
//     inA     in   operand A (captured with start)
//     inB     in   operand B (captured with start)
//     busy    out  high in RUN and DONE
//     done    out  one-cycle pulse, result/cout/ovf valid
//     result  out  sum/difference, held until next accepted start
//     cout    out  carry out of MSB (subtract: 1 = no borrow)
//     ovf     out  signed overflow
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [WIDTH-1:0] res_sh;
    logic             cout_q;
    logic             ovf_q;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_next)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            res_sh <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry.
                        a_sh   <= inA;
                        b_sh   <= (op_sub == OP_SUB) ? ~inB : inB;
                        carry  <= (op_sub == OP_SUB);
                        cnt    <= '0;
                        res_sh <= '0;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    // Sum bits enter at the MSB and walk down, so after WIDTH
                    // shifts bit 0 of the answer sits at result[0].
                    res_sh <= {s_bit, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_next;
                    if (last_bit) begin
                        // Flags are latched on the way into DONE so they are
                        // already valid during the done cycle. 'carry' here is
                        // the carry into the MSB.
                        cout_q <= c_next;
                        ovf_q  <= carry ^ c_next;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = res_sh;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .inA    (inA),
        .inB    (inB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic v);
        exp_t e;
        e.res = r;
        e.co  = c;
        e.ov  = v;
        return e;
    endfunction

    // Reference: wide add for value/carry, sign rules for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub);
        logic [WIDTH:0] full;
        exp_t           e;
        if (sub) full = {1'b0, a} - {1'b0, b} + (WIDTH+1)'(1 << WIDTH);
        else     full = {1'b0, a} + {1'b0, b};
        e.res = full[WIDTH-1:0];
        e.co  = full[WIDTH];
        if (!sub) e.ov = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        else      e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result.
    always begin
        @(posedge clk);
        #1;
        if (done) begin
            chk("done_single", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("cout",   {31'd0, cout},   {31'd0, e.co});
                chk("ovf",    {31'd0, ovf},    {31'd0, e.ov});
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input exp_t e);
        int lat;
        wait_idle();
        inA    = a;
        inB    = b;
        op_sub = sub;
        start  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        // Operands change right after capture; must not disturb the op.
        start  = 1'b0;
        inA    = WIDTH'($urandom);
        inB    = WIDTH'($urandom);
        op_sub = 1'($urandom);
        lat    = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < WIDTH + 4);
        chk("latency", lat, WIDTH);
    endtask

    initial begin
        int   ndone;
        logic kept;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rs;

        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        inA    = '0;
        inB    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout",   {31'd0, cout},   32'd0);
        chk("rst_ovf",    {31'd0, ovf},    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed adds and subtracts
        do_op(8'h35, 8'h4A, 1'b0, mk(8'h7F, 1'b0, 1'b0));
        do_op(8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0));
        do_op(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1));
        do_op(8'h10, 8'h20, 1'b1, mk(8'hF0, 1'b0, 1'b0));
        do_op(8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b1, 1'b1));

        // Result holds in IDLE
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", {24'd0, result}, 32'h7F);
        chk("hold_cout",   {31'd0, cout},   32'd1);
        chk("hold_ovf",    {31'd0, ovf},    32'd1);

        // start held high through RUN and DONE with changing operands
        wait_idle();
        inA    = 8'h12;
        inB    = 8'h34;
        op_sub = 1'b0;
        start  = 1'b1;
        sb.push_back(mk(8'h46, 1'b0, 1'b0));
        ndone = 0;
        kept  = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            @(negedge clk);
            if (ndone == 0 || (done && !kept)) begin
                if (ndone != 0) kept = 1'b1;
                inA    = WIDTH'($urandom);
                inB    = WIDTH'($urandom);
                op_sub = 1'($urandom);
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_ndone", ndone, 1);
        chk("busy_idle",  {31'd0, busy}, 32'd0);
        chk("busy_kept",  {31'd0, kept}, 32'd1);

        // Reset three cycles into RUN
        wait_idle();
        inA    = 8'h55;
        inB    = 8'h22;
        op_sub = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",   {31'd0, busy},   32'd0);
        chk("abort_done",   {31'd0, done},   32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_cout",   {31'd0, cout},   32'd0);
        chk("abort_ovf",    {31'd0, ovf},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (WIDTH + 2) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        do_op(8'h01, 8'h01, 1'b0, mk(8'h02, 1'b0, 1'b0));

        // Random ops against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            do_op(ra, rb, rs, model(ra, rb, rs));
        end

        repeat (4) @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
